// File: rtl/ram_responder_pkg.sv
// Shared types and limits for the ram_responder memory-side read handshake.
package ram_responder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/ram_responder_array.sv
// Word-addressed storage: synchronous write, combinational read.
module ram_array #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb rd_data = mem[rd_addr];

endmodule

// File: rtl/ram_responder.sv
// Fixed-latency read responder: accepts a req pulse, snapshots the word, and
// returns it with a one-cycle rvalid LATENCY cycles later.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [AWIDTH-1:0] addr,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              overrun
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $fatal(1, "ram_responder: LATENCY must be within 1..15");
  end

  logic [DWIDTH-1:0] mem_word;
  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] hold;
  logic [CNT_W-1:0]  cnt;
  state_t            state;

  ram_array #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (addr),
    .rd_data (mem_word)
  );

  // Write-first bypass so a same-cycle write to the requested word is captured.
  always_comb rd_word = (wr_en && (wr_addr == addr)) ? wr_data : mem_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hold    <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (LATENCY == 1) begin
              rdata  <= rd_word;
              rvalid <= 1'b1;
            end else begin
              hold  <= rd_word;
              cnt   <= CNT_W'(LATENCY - 1);
              busy  <= 1'b1;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (req) overrun <= 1'b1;
          cnt <= cnt - CNT_W'(1);
          // Issue on the edge that takes the counter to zero, freeing IDLE for
          // a back-to-back request in the rvalid cycle.
          if (cnt == CNT_W'(1)) begin
            rdata  <= hold;
            rvalid <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench: four responders (LATENCY 2,4,3,1) share one write port
// and are checked every cycle against a timestamp-based response model.
module tb_ram_responder;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        req     [NDUT];
  logic [7:0]  addr    [NDUT];
  logic [15:0] rdata   [NDUT];
  logic        rvalid  [NDUT];
  logic        busy    [NDUT];
  logic        overrun [NDUT];

  always #5 clk = ~clk;

  ram_responder #(.DWIDTH(16), .AWIDTH(8), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req(req[0]), .addr(addr[0]), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rdata(rdata[0]), .rvalid(rvalid[0]),
    .busy(busy[0]), .overrun(overrun[0]));

  ram_responder #(.DWIDTH(16), .AWIDTH(8), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req(req[1]), .addr(addr[1]), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rdata(rdata[1]), .rvalid(rvalid[1]),
    .busy(busy[1]), .overrun(overrun[1]));

  ram_responder #(.DWIDTH(16), .AWIDTH(8), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req(req[2]), .addr(addr[2]), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rdata(rdata[2]), .rvalid(rvalid[2]),
    .busy(busy[2]), .overrun(overrun[2]));

  ram_responder #(.DWIDTH(16), .AWIDTH(8), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req(req[3]), .addr(addr[3]), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rdata(rdata[3]), .rvalid(rvalid[3]),
    .busy(busy[3]), .overrun(overrun[3]));

  // Reference model: shadow memory plus, per DUT, the cycle its response is due.
  logic [15:0] mem_m [256];
  bit          pend  [NDUT];
  int          due   [NDUT];
  logic [15:0] pdata [NDUT];
  logic [15:0] last  [NDUT];
  bit          ov    [NDUT];
  int          cyc;
  int          errs;
  int          checks;

  function automatic int lat_of(int k);
    case (k)
      0:       return 2;
      1:       return 4;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic chk(string tag, int k, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance the model by this cycle's inputs.
  task automatic tick();
    bit erv;
    bit ebusy;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        pend[k] = 1'b0;
        last[k] = '0;
        ov[k]   = 1'b0;
      end
      erv   = pend[k] && (due[k] == cyc);
      ebusy = pend[k] && (due[k] > cyc);
      if (erv) last[k] = pdata[k];
      chk("rvalid",  k, {15'd0, rvalid[k]},  {15'd0, erv});
      chk("busy",    k, {15'd0, busy[k]},    {15'd0, ebusy});
      chk("rdata",   k, rdata[k],            last[k]);
      chk("overrun", k, {15'd0, overrun[k]}, {15'd0, ov[k]});
      if (!rst) begin
        if (erv) pend[k] = 1'b0;
        if (req[k]) begin
          if (ebusy) ov[k] = 1'b1;
          else begin
            pend[k]  = 1'b1;
            due[k]   = cyc + lat_of(k);
            pdata[k] = (wr_en && (wr_addr == addr[k])) ? wr_data : mem_m[addr[k]];
          end
        end
      end
    end
    if (wr_en) mem_m[wr_addr] = wr_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_word(logic [7:0] a, logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue(int k, logic [7:0] a);
    req[k] = 1'b1; addr[k] = a;
    tick();
    req[k] = 1'b0;
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int k = 0; k < NDUT; k++) begin
      req[k] = 1'b0; addr[k] = '0; pend[k] = 1'b0; due[k] = 0;
      pdata[k] = '0; last[k] = '0; ov[k] = 1'b0;
    end
    idle(3);
    rst = 1'b0;

    // Preload every word so all later reads are defined.
    for (int a = 0; a < 256; a++) write_word(8'(a), 16'($urandom));

    // Write then read at LATENCY=2.
    write_word(8'h05, 16'hBEEF);
    idle(5);
    issue(0, 8'h05);
    chk("s1_busy", 0, {15'd0, busy[0]}, 16'd1);
    chk("s1_early_rvalid", 0, {15'd0, rvalid[0]}, 16'd0);
    tick();
    chk("s1_rvalid", 0, {15'd0, rvalid[0]}, 16'd1);
    chk("s1_rdata", 0, rdata[0], 16'hBEEF);
    tick();
    chk("s1_rvalid_drop", 0, {15'd0, rvalid[0]}, 16'd0);
    idle(2);

    // Back-to-back: second request lands in the rvalid cycle.
    write_word(8'h01, 16'h1111);
    write_word(8'h02, 16'h2222);
    issue(0, 8'h01);
    tick();
    issue(0, 8'h02);
    idle(3);
    chk("s2_rdata", 0, rdata[0], 16'h2222);
    chk("s2_overrun", 0, {15'd0, overrun[0]}, 16'd0);

    // Overrun at LATENCY=4: second request ignored, flag sticky.
    issue(1, 8'h01);
    issue(1, 8'h02);
    idle(5);
    chk("s3_rdata", 1, rdata[1], 16'h1111);
    chk("s3_overrun", 1, {15'd0, overrun[1]}, 16'd1);

    // Write-first capture, then a write during WAIT must not disturb it.
    write_word(8'h07, 16'h0001);
    req[0] = 1'b1; addr[0] = 8'h07;
    wr_en = 1'b1; wr_addr = 8'h07; wr_data = 16'h00AA;
    tick();
    req[0] = 1'b0;
    write_word(8'h07, 16'h5555);
    idle(3);
    chk("s4_rdata", 0, rdata[0], 16'h00AA);

    // Reset while a LATENCY=3 request is outstanding.
    issue(2, 8'h05);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(5);
    chk("s5_rdata", 2, rdata[2], 16'h0000);
    chk("s5_overrun", 1, {15'd0, overrun[1]}, 16'd0);
    issue(2, 8'h05);
    idle(4);
    chk("s5_fresh", 2, rdata[2], 16'hBEEF);

    // LATENCY=1 streaming, one request per cycle.
    for (int a = 0; a < 8; a++) begin
      req[3] = 1'b1; addr[3] = 8'(a);
      tick();
    end
    req[3] = 1'b0;
    idle(2);
    chk("s6_rdata", 3, rdata[3], mem_m[8'h07]);

    // Randomised traffic on all four responders.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NDUT; k++) begin
        req[k]  = ($urandom_range(0, 2) == 0);
        addr[k] = 8'($urandom_range(0, 15));
      end
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = 8'($urandom_range(0, 15));
      wr_data = 16'($urandom);
      tick();
    end
    for (int k = 0; k < NDUT; k++) req[k] = 1'b0;
    wr_en = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the CPU fetch/load handshake. Accepts a one-cycle read request pulse plus address from the control unit, and returns a DWIDTH-bit word with a one-cycle valid pulse after a fixed, parameterised latency.
- The control unit's fetch pulse drives req, and the PC or offset address drives addr. rdata/rvalid feed the instruction-register input and its load enable.
- A side write port loads program and data words into the array.

Parameters:
- DWIDTH, 16, word width of the array and rdata.
- AWIDTH, 8, address width; array depth is 2**AWIDTH words.
- LATENCY, 2, cycles from request cycle to rvalid cycle. Legal range is 1..15; out-of-range values are a elaboration-time error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  read request pulse, sampled on rising clk.
- addr  input  AWIDTH  read address, valid with req.
- wr_en  input  1  write strobe for the array.
- wr_addr  input  AWIDTH  write address.
- wr_data  input  DWIDTH  write data.
- rdata  output  DWIDTH  response word; holds its last value between responses.
- rvalid  output  1  one-cycle response strobe.
- busy  output  1  request outstanding, new req will not be accepted.
- overrun  output  1  sticky flag: a req arrived while busy.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE and the latency counter is cleared.
  - Outputs reset to rdata=0, rvalid=0, busy=0, overrun=0.
  - Array contents are not reset.
  - An outstanding request is dropped; no rvalid is ever produced for it.
- FSM states: IDLE and WAIT.
- IDLE:
  - req=1 in cycle c accepts the request.
  - The hold register captures mem[addr] at that edge.
  - Counter is loaded with LATENCY-1.
  - Next state is WAIT if LATENCY>1; if LATENCY=1, the response is issued directly.
- WAIT:
  - Counter decrements each cycle.
  - When it reaches 0, rvalid=1 and rdata=hold for exactly one cycle, and the FSM returns to IDLE.
- Timing:
  - A request accepted in cycle c produces rvalid high in cycle c+LATENCY only.
  - rdata changes only at the edge that raises rvalid.
- busy:
  - High in cycles c+1 .. c+LATENCY-1.
  - Low in the rvalid cycle, so back-to-back requests are allowed: a req in the rvalid cycle is accepted.
  - With LATENCY=1, busy is never high, and one request per cycle is sustained.
- req while busy=1:
  - The request is ignored; no capture, no extra rvalid.
  - overrun is set to 1 and stays set until rst.
- Writes:
  - Synchronous: mem[wr_addr] <= wr_data on any cycle with wr_en=1, in any FSM state.
  - Same-cycle write and accept to the same address is write-first: the hold register captures wr_data.
  - A write after acceptance does not alter the already-captured response word.
- Addresses are AWIDTH bits, so no out-of-range access is possible. No address wrap logic is needed beyond natural width.
- req held high for multiple cycles:
  - With LATENCY>1, each cycle after acceptance while busy counts as an overrun.
  - Masters must pulse req.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_WAIT).
  - LATENCY_MIN=1 and LATENCY_MAX=15.
  - Counter width constant CNT_W=4.
- One natural sub-module: ram_array.
  - 2**AWIDTH x DWIDTH.
  - Synchronous write, asynchronous (combinational) read.
  - Keeps the storage separable from the handshake FSM.

Test Plan:
- Reset then rw: write mem[0x05]=0xBEEF, req addr=0x05 in cycle 10 (LATENCY=2) -> rvalid high only in cycle 12, rdata=0xBEEF, busy high in cycle 11 only.
- Back-to-back: mem[1]=0x1111, mem[2]=0x2222. req addr=1 at cycle c, req addr=2 at cycle c+2 (rvalid cycle), LATENCY=2 -> rvalid at c+2 with 0x1111 and at c+4 with 0x2222, overrun=0.
- Overrun: LATENCY=4, req at c, second req at c+1 -> single rvalid at c+4 with first address's data, overrun=1 from c+2 until rst.
- Write-first and snapshot: mem[7]=0x0001. In the same cycle, req addr=7 with wr_en wr_addr=7 wr_data=0x00AA -> response 0xAA. Then write mem[7]=0x5555 during WAIT -> response still 0xAA.
- Reset mid-operation: LATENCY=3, req at c, rst pulsed in c+1 -> no rvalid ever, busy=0, rdata=0, overrun=0. A fresh req afterward is accepted normally.
- LATENCY=1 streaming: req every cycle over addresses 0..7 -> rvalid every following cycle with matching data, busy never asserted.
